// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory read arbiter.
package mem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 32'd0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first unmasked request after ptr, with wrap.
module rr_priority_pick
  import mem_arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] w_eff;
  logic         w_found;
  int unsigned  w_start;
  int unsigned  w_cand;

  always_comb begin
    w_eff   = req & ~mask;
    any     = |w_eff;
    idx     = '0;
    w_found = 1'b0;
    w_start = rr_next(32'(ptr), N);
    w_cand  = 0;
    for (int unsigned off = 0; off < N; off++) begin
      w_cand = w_start + off;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!w_found && w_eff[IDX_W'(w_cand)]) begin
        w_found = 1'b1;
        idx     = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-outstanding memory read port between NUM_REQ engines.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned ADDR_WIDTH = 64,
  parameter  int unsigned DATA_WIDTH = 64,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_resp,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          mem_read,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_resp,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy
);

  arb_state_e              r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]        r_grant, w_grant_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;

  logic [NUM_REQ-1:0]      w_grant_oh;
  logic [NUM_REQ-1:0]      w_pick_mask;
  logic [IDX_W-1:0]        w_pick_ptr;
  logic                    w_pick_any;
  logic [IDX_W-1:0]        w_pick_idx;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;

  always_comb begin
    w_grant_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) w_grant_oh[i] = (r_grant == IDX_W'(i));
  end

  // One picker serves both paths: in BUSY it scans after the served requester, which is masked out.
  always_comb begin
    w_pick_mask = '0;
    w_pick_ptr  = r_ptr;
    if (r_state == ARB_BUSY) begin
      w_pick_mask = w_grant_oh;
      w_pick_ptr  = r_grant;
    end
  end

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .req  (req_read),
    .mask (w_pick_mask),
    .ptr  (w_pick_ptr),
    .any  (w_pick_any),
    .idx  (w_pick_idx)
  );

  always_comb begin
    w_sel_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (w_pick_idx == IDX_W'(i)) w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_addr_nxt  = r_addr;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_idx;
          w_addr_nxt  = w_sel_addr;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_resp) begin
          w_ptr_nxt = r_grant;
          if (w_pick_any) begin
            w_grant_nxt = w_pick_idx;
            w_addr_nxt  = w_sel_addr;
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_grant <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign mem_read  = (r_state == ARB_BUSY);
  assign busy      = (r_state == ARB_BUSY);
  assign mem_addr  = r_addr;
  assign grant_id  = r_grant;
  assign req_rdata = mem_rdata;
  assign req_resp  = (r_state == ARB_BUSY && mem_resp) ? w_grant_oh : '0;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed self-checking bench for mem_rr_arbiter (4 requesters, 64-bit address/data).
module tb_mem_rr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_read;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]   req_resp;
  logic [DW-1:0]   req_rdata;
  logic            mem_read;
  logic [AW-1:0]   mem_addr;
  logic            mem_resp;
  logic [DW-1:0]   mem_rdata;
  logic [1:0]      grant_id;
  logic            busy;

  int n_tests;
  int n_fail;

  mem_rr_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_read  (req_read),
    .req_addr  (req_addr),
    .req_resp  (req_resp),
    .req_rdata (req_rdata),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_resp  (mem_resp),
    .mem_rdata (mem_rdata),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_read  = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mem_read"}, 64'(mem_read), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_req_resp"}, 64'(req_resp), 64'd0);
  endtask

  int ord [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    req_addr = '0;
    do_reset();
    #1;
    // Reset state
    chk_idle("rst");
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);

    // 1: single requester 2, resp 3 cycles after request
    req_read = 4'b0100;
    req_addr[2*AW +: AW] = 64'h100;
    #1;
    chk("t1_c0_mem_read", 64'(mem_read), 64'd0);
    tick();
    chk("t1_c1_mem_read", 64'(mem_read), 64'd1);
    chk("t1_c1_mem_addr", mem_addr, 64'h100);
    chk("t1_c1_grant", 64'(grant_id), 64'd2);
    chk("t1_c1_busy", 64'(busy), 64'd1);
    tick();
    chk("t1_c2_req_resp", 64'(req_resp), 64'd0);
    chk("t1_c2_mem_read", 64'(mem_read), 64'd1);
    tick();
    mem_resp = 1'b1; mem_rdata = 64'hAB;
    #1;
    chk("t1_c3_req_resp", 64'(req_resp), 64'b0100);
    chk("t1_c3_rdata", req_rdata, 64'hAB);
    tick();
    mem_resp = 1'b0; req_read = '0;
    #1;
    chk_idle("t1_c4");
    chk("t1_c4_grant", 64'(grant_id), 64'd2);

    // 2: all four requesting continuously
    do_reset();
    for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = 64'h1000 + 64'(i);
    req_read = 4'b1111;
    tick();
    for (int k = 0; k < 6; k++) begin
      mem_resp = 1'b0;
      #1;
      chk("t2_grant", 64'(grant_id), 64'(ord[k]));
      chk("t2_mem_addr", mem_addr, 64'h1000 + 64'(ord[k]));
      chk("t2_mem_read_a", 64'(mem_read), 64'd1);
      chk("t2_noresp", 64'(req_resp), 64'd0);
      tick();
      mem_resp = 1'b1; mem_rdata = 64'h50 + 64'(k);
      #1;
      chk("t2_req_resp", 64'(req_resp), 64'(1 << ord[k]));
      chk("t2_rdata", req_rdata, 64'h50 + 64'(k));
      chk("t2_mem_read_b", 64'(mem_read), 64'd1);
      tick();
    end
    mem_resp = 1'b0;
    #1;
    chk("t2_tail_grant", 64'(grant_id), 64'd2);
    tick();
    mem_resp = 1'b1; req_read = 4'b0100;
    #1;
    chk("t2_tail_resp", 64'(req_resp), 64'b0100);
    tick();
    mem_resp = 1'b0; req_read = '0;
    #1;
    chk_idle("t2_end");

    // 3: pointer=1, requesters 1 and 3
    do_reset();
    req_read = 4'b0010;
    tick();
    chk("t3_setup_grant", 64'(grant_id), 64'd1);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0; req_read = '0;
    tick();
    req_read = 4'b1010;
    tick();
    chk("t3_first_grant", 64'(grant_id), 64'd3);
    chk("t3_first_mem_read", 64'(mem_read), 64'd1);
    tick();
    mem_resp = 1'b1;
    #1;
    chk("t3_first_resp", 64'(req_resp), 64'b1000);
    tick();
    mem_resp = 1'b0; req_read = 4'b0010;
    #1;
    chk("t3_second_grant", 64'(grant_id), 64'd1);
    chk("t3_no_idle", 64'(mem_read), 64'd1);
    tick();
    mem_resp = 1'b1;
    #1;
    chk("t3_second_resp", 64'(req_resp), 64'b0010);
    tick();
    mem_resp = 1'b0; req_read = '0;
    #1;
    chk_idle("t3_end");

    // 4: granted requester drops request and changes address mid-BUSY
    do_reset();
    req_read = 4'b0001;
    req_addr[0 +: AW] = 64'h200;
    tick();
    chk("t4_grant", 64'(grant_id), 64'd0);
    chk("t4_addr_a", mem_addr, 64'h200);
    req_read = '0;
    req_addr[0 +: AW] = 64'h300;
    tick();
    chk("t4_addr_b", mem_addr, 64'h200);
    chk("t4_mem_read", 64'(mem_read), 64'd1);
    tick();
    mem_resp = 1'b1;
    #1;
    chk("t4_resp", 64'(req_resp), 64'b0001);
    tick();
    mem_resp = 1'b0;
    #1;
    chk_idle("t4_end");

    // 5: reset during BUSY, stray resp afterwards
    req_read = 4'b0100;
    tick();
    chk("t5_busy", 64'(busy), 64'd1);
    chk("t5_grant", 64'(grant_id), 64'd2);
    rst = 1'b1; req_read = '0;
    tick();
    rst = 1'b0;
    #1;
    chk_idle("t5_after_rst");
    chk("t5_grant_rst", 64'(grant_id), 64'd0);
    tick();
    mem_resp = 1'b1;
    #1;
    chk_idle("t5_stray");
    tick();
    mem_resp = 1'b0; req_read = 4'b0101;
    tick();
    chk("t5_next_grant", 64'(grant_id), 64'd0);
    mem_resp = 1'b1;
    #1;
    chk("t5_next_resp", 64'(req_resp), 64'b0001);
    tick();
    mem_resp = 1'b0; req_read = '0;
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;

    // 6: mem_resp while IDLE with no requests
    do_reset();
    mem_resp = 1'b1; mem_rdata = 64'hDEAD;
    #1;
    chk_idle("t6_a");
    tick();
    #1;
    chk_idle("t6_b");
    chk("t6_mem_addr", mem_addr, 64'd0);
    chk("t6_grant", 64'(grant_id), 64'd0);
    mem_resp = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
